// File: rtl/simon_batch_sequencer.sv
// Batch controller for the Simon 64/128 core. It issues core starts, optionally chains
// each ciphertext into the next plaintext, counts completions and watchdogs every block.
module simon_batch_sequencer #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024,
    parameter int GAP     = 4
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             cfg_go,
    input  logic             cfg_abort,
    input  logic             cfg_chain,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic [63:0]      pt_in,
    output logic             core_start,
    output logic [63:0]      core_pt,
    input  logic             core_eoc,
    input  logic [63:0]      core_ct,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    output logic [CNT_W-1:0] ops_done,
    output logic [63:0]      last_ct
);

    localparam int WD_W  = $clog2(TIMEOUT);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    // The watchdog reads 0 in the first WAIT cycle, so TIMEOUT-2 is the last WAIT cycle
    // in which an eoc is still accepted; the error flag then shows TIMEOUT cycles after start.
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 2);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_GAP
    } state_t;

    state_t state, state_d;

    logic [CNT_W-1:0] count_q;
    logic             chain_q;
    logic [WD_W-1:0]  wdog;
    logic [GAP_W-1:0] gap_cnt;

    logic accept;
    logic zero_go;
    logic take_eoc;
    logic timeout_hit;
    logic done_d;
    logic last_blk;

    assign last_blk   = (ops_done + CNT_W'(1)) == count_q;
    assign core_start = (state == ST_START);
    assign busy       = (state != ST_IDLE);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
        state_d     = state;
        accept      = 1'b0;
        zero_go     = 1'b0;
        take_eoc    = 1'b0;
        timeout_hit = 1'b0;
        done_d      = 1'b0;

        if (state != ST_IDLE && cfg_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cfg_go) begin
                        if (cfg_count == '0) begin
                            zero_go = 1'b1;
                            done_d  = 1'b1;
                        end else begin
                            accept  = 1'b1;
                            state_d = ST_START;
                        end
                    end
                end
                ST_START: state_d = ST_WAIT;
                ST_WAIT: begin
                    if (core_eoc) begin
                        take_eoc = 1'b1;
                        if (last_blk) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else if (GAP > 0) begin
                            state_d = ST_GAP;
                        end else begin
                            state_d = ST_START;
                        end
                    end else if (wdog == WD_LAST) begin
                        timeout_hit = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) state_d = ST_START;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (!n_reset) state <= ST_IDLE;
        else          state <= state_d;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        // NOTE: all datapath registers are reset, since every output must read 0 straight out of reset.
        if (!n_reset) begin
            count_q     <= '0;
            chain_q     <= 1'b0;
            core_pt     <= '0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            ops_done    <= '0;
            last_ct     <= '0;
            wdog        <= '0;
            gap_cnt     <= '0;
        end else begin
            done <= done_d;

            if (accept) begin
                count_q <= cfg_count;
                chain_q <= cfg_chain;
                core_pt <= pt_in;
            end
            if (accept || zero_go) begin
                ops_done    <= '0;
                err_timeout <= 1'b0;
            end
            if (take_eoc) begin
                last_ct  <= core_ct;
                ops_done <= ops_done + CNT_W'(1);
                if (chain_q) core_pt <= core_ct;
            end
            if (timeout_hit) err_timeout <= 1'b1;

            if (state == ST_START)     wdog <= '0;
            else if (state == ST_WAIT) wdog <= wdog + WD_W'(1);

            if (state == ST_GAP) gap_cnt <= gap_cnt + GAP_W'(1);
            else                 gap_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_simon_batch_sequencer.sv
// Directed and randomized batches against a behavioural core model and a per-batch
// reference of the expected plaintext sequence, start spacing and completion results.
module tb_simon_batch_sequencer;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1024;
    localparam int GAP     = 4;
    localparam logic [63:0] FIXED_CT = 64'h0000_0000_C69B_E9BB;

    logic             clk = 1'b0;
    logic             n_reset = 1'b0;
    logic             cfg_go = 1'b0;
    logic             cfg_abort = 1'b0;
    logic             cfg_chain = 1'b0;
    logic [CNT_W-1:0] cfg_count = '0;
    logic [63:0]      pt_in = '0;
    logic             core_start;
    logic [63:0]      core_pt;
    logic             core_eoc = 1'b0;
    logic [63:0]      core_ct = '0;
    logic             busy;
    logic             done;
    logic             err_timeout;
    logic [CNT_W-1:0] ops_done;
    logic [63:0]      last_ct;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // core model controls (written by the stimulus) and state (written by the model)
    int          lat = 10;
    bit          fixed_mode = 1'b0;
    bit          no_eoc = 1'b0;
    int          stray_cnt = 0;
    int          stray_seen = 0;
    bit          pend = 1'b0;
    int          cd = 0;
    logic [63:0] pt_cap = '0;
    logic [63:0] start_pts[$];
    int          start_cyc[$];
    int          dones = 0;
    int          done_cyc = 0;
    int          go_cyc = 0;

    simon_batch_sequencer #(
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT),
        .GAP    (GAP)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .cfg_go     (cfg_go),
        .cfg_abort  (cfg_abort),
        .cfg_chain  (cfg_chain),
        .cfg_count  (cfg_count),
        .pt_in      (pt_in),
        .core_start (core_start),
        .core_pt    (core_pt),
        .core_eoc   (core_eoc),
        .core_ct    (core_ct),
        .busy       (busy),
        .done       (done),
        .err_timeout(err_timeout),
        .ops_done   (ops_done),
        .last_ct    (last_ct)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Core model: eoc exactly 'lat' cycles after the start it answers, ct = pt+1 or a constant.
    always @(negedge clk) begin
        core_eoc = 1'b0;
        if (!n_reset) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (cd <= 1) begin
                    core_eoc = 1'b1;
                    core_ct  = fixed_mode ? FIXED_CT : pt_cap + 64'd1;
                    pend     = 1'b0;
                end else begin
                    cd--;
                end
            end
            if (stray_cnt != stray_seen) begin
                core_eoc   = 1'b1;
                core_ct    = 64'hDEAD_BEEF_0BAD_F00D;
                stray_seen = stray_cnt;
            end
            if (core_start === 1'b1) begin
                start_pts.push_back(core_pt);
                start_cyc.push_back(cyc);
                pt_cap = core_pt;
                pend   = !no_eoc;
                cd     = lat;
            end
        end
    end

    always @(negedge clk) begin
        if (done === 1'b1) begin
            dones++;
            done_cyc = cyc;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: observed=still running required=finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_core_start"}, 64'(core_start), 64'd0);
        check({tag, "_core_pt"}, core_pt, 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_err"}, 64'(err_timeout), 64'd0);
        check({tag, "_ops_done"}, 64'(ops_done), 64'd0);
        check({tag, "_last_ct"}, last_ct, 64'd0);
    endtask

    task automatic pulse_go(input logic [CNT_W-1:0] n, input logic ch, input logic [63:0] pt);
        @(negedge clk);
        cfg_go    = 1'b1;
        cfg_count = n;
        cfg_chain = ch;
        pt_in     = pt;
        go_cyc    = cyc;
        @(negedge clk);
        cfg_go    = 1'b0;
        cfg_count = CNT_W'($urandom);
        cfg_chain = ~ch;
        pt_in     = {$urandom, $urandom};
    endtask

    task automatic wait_idle(input int bound, input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(n < bound), 64'd1);
    endtask

    // Runs one batch and checks it against the plaintext/ciphertext sequence the rules imply.
    // poke >= 0 fires an extra cfg_go that many cycles into the batch (must be ignored).
    task automatic run_batch(input string tag, input int n, input logic ch, input logic [63:0] pt,
                             input int l, input bit fixed, input int poke);
        int          b  = start_pts.size();
        int          d0 = dones;
        logic [63:0] exp_pt = pt;
        logic [63:0] ct = '0;
        lat        = l;
        fixed_mode = fixed;
        no_eoc     = 1'b0;
        pulse_go(CNT_W'(n), ch, pt);
        if (poke >= 0) begin
            repeat (poke) @(negedge clk);
            cfg_go    = 1'b1;
            cfg_count = CNT_W'(n + 5);
            pt_in     = ~pt;
            cfg_chain = ~ch;
            @(negedge clk);
            cfg_go = 1'b0;
        end
        wait_idle(n * (l + GAP + 2) + 20, {tag, "_bound"});
        @(negedge clk);
        check({tag, "_starts"}, 64'(start_pts.size() - b), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (b + i < start_pts.size()) begin
                check($sformatf("%s_pt%0d", tag, i), start_pts[b + i], exp_pt);
                if (i == 0)
                    check({tag, "_first_start"}, 64'(start_cyc[b]), 64'(go_cyc + 1));
                else
                    check($sformatf("%s_gap%0d", tag, i), 64'(start_cyc[b + i] - start_cyc[b + i - 1]),
                          64'(l + GAP + 1));
            end
            ct     = fixed ? FIXED_CT : exp_pt + 64'd1;
            exp_pt = ch ? ct : pt;
        end
        check({tag, "_last_ct"}, last_ct, ct);
        check({tag, "_ops_done"}, 64'(ops_done), 64'(n));
        check({tag, "_dones"}, 64'(dones - d0), 64'd1);
        if (start_pts.size() > b)
            check({tag, "_done_cyc"}, 64'(done_cyc), 64'(start_cyc[start_pts.size() - 1] + l + 1));
        check({tag, "_err"}, 64'(err_timeout), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic zero_batch(input string tag);
        int b  = start_pts.size();
        int d0 = dones;
        pulse_go('0, 1'b0, {$urandom, $urandom});
        @(negedge clk);
        check({tag, "_dones"}, 64'(dones - d0), 64'd1);
        check({tag, "_done_cyc"}, 64'(done_cyc), 64'(go_cyc + 1));
        check({tag, "_starts"}, 64'(start_pts.size() - b), 64'd0);
        check({tag, "_ops_done"}, 64'(ops_done), 64'd0);
        check({tag, "_err"}, 64'(err_timeout), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int          b;
        int          d0;
        int          n;
        logic        ch;
        logic [63:0] pt;
        logic [63:0] ct1;
        logic [63:0] ct2;
        logic [63:0] prev_ct;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        n_reset = 1'b1;
        repeat (2) @(negedge clk);

        run_batch("single", 1, 1'b0, 64'h6565_6877_2064_6e61, 40, 1'b1, -1);
        run_batch("chain3", 3, 1'b1, {$urandom, $urandom}, 25, 1'b0, -1);
        run_batch("reuse3", 3, 1'b0, {$urandom, $urandom}, 17, 1'b0, -1);
        run_batch("go_busy", 2, 1'b1, {$urandom, $urandom}, 15, 1'b0, 5);
        run_batch("wd_edge", 1, 1'b0, {$urandom, $urandom}, TIMEOUT - 1, 1'b0, -1);

        for (int k = 0; k < 6; k++)
            run_batch($sformatf("rnd%0d", k), int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)),
                      {$urandom, $urandom}, int'($urandom_range(1, 60)), 1'b0, -1);

        // watchdog: core never answers
        no_eoc = 1'b1;
        d0 = dones;
        pulse_go(CNT_W'(1), 1'b0, {$urandom, $urandom});
        repeat (TIMEOUT - 1) @(negedge clk);
        check("wd_err_before", 64'(err_timeout), 64'd0);
        check("wd_busy_before", 64'(busy), 64'd1);
        @(negedge clk);
        check("wd_err_at", 64'(err_timeout), 64'd1);
        check("wd_busy_at", 64'(busy), 64'd0);
        @(negedge clk);
        check("wd_no_done", 64'(dones - d0), 64'd0);
        check("wd_ops_done", 64'(ops_done), 64'd0);
        no_eoc = 1'b0;
        zero_batch("zero_after_wd");

        // abort after the second completion, then a stray eoc
        lat        = 20;
        fixed_mode = 1'b0;
        ch         = 1'($urandom_range(0, 1));
        pt         = {$urandom, $urandom};
        b          = start_pts.size();
        d0         = dones;
        pulse_go(CNT_W'(5), ch, pt);
        n = 0;
        while (ops_done !== CNT_W'(2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_wait_bound", 64'(n < 200), 64'd1);
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        repeat (100) @(negedge clk);
        ct1 = pt + 64'd1;
        ct2 = (ch ? ct1 : pt) + 64'd1;
        check("abort_starts", 64'(start_pts.size() - b), 64'd2);
        check("abort_ops_done", 64'(ops_done), 64'd2);
        check("abort_last_ct", last_ct, ct2);
        check("abort_no_done", 64'(dones - d0), 64'd0);
        stray_cnt++;
        repeat (3) @(negedge clk);
        check("stray_ops_done", 64'(ops_done), 64'd2);
        check("stray_last_ct", last_ct, ct2);
        check("stray_busy", 64'(busy), 64'd0);
        check("stray_starts", 64'(start_pts.size() - b), 64'd2);
        zero_batch("zero_after_abort");

        // abort in the very cycle the eoc arrives: the eoc is dropped
        prev_ct = last_ct;
        lat     = 30;
        d0      = dones;
        pulse_go(CNT_W'(2), 1'b1, {$urandom, $urandom});
        repeat (lat) @(negedge clk);
        cfg_abort = 1'b1;
        @(negedge clk);
        cfg_abort = 1'b0;
        check("abort_eoc_busy", 64'(busy), 64'd0);
        check("abort_eoc_ops_done", 64'(ops_done), 64'd0);
        check("abort_eoc_last_ct", last_ct, prev_ct);
        @(negedge clk);
        check("abort_eoc_no_done", 64'(dones - d0), 64'd0);

        // asynchronous reset in the middle of a WAIT
        lat = 100;
        pulse_go(CNT_W'(3), 1'b1, {$urandom, $urandom});
        repeat (10) @(negedge clk);
        check("pre_reset_busy", 64'(busy), 64'd1);
        #2 n_reset = 1'b0;
        #1 check_all_zero("async_reset");
        @(negedge clk);
        #2 n_reset = 1'b1;
        b = start_pts.size();
        repeat (120) @(negedge clk);
        check("post_reset_busy", 64'(busy), 64'd0);
        check("post_reset_starts", 64'(start_pts.size() - b), 64'd0);
        run_batch("post_reset", 2, 1'b1, {$urandom, $urandom}, 12, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
